// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
//
// Two-master Avalon-MM arbiter. Master I (instruction fetch) and master D
// (load/store) share one Avalon memory bus that has waitrequest. A registered
// grant state machine picks the owner. The owner's transaction goes to the
// shared bus unchanged, and ownership is held until the slave completes it.
// Nothing is buffered. Each master must hold its request stable while its
// waitrequest is high.
//
// Parameters
//   ADDR_W     address width of all ports
//   DATA_W     data width; byteenable width is DATA_W/8
//   FIXED_PRIO 0 = round-robin on a simultaneous request, 1 = D always wins
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   i_* / d_*           master I / master D Avalon slave-side ports
//                       (address, read, write, writedata, byteenable in;
//                        waitrequest, readdata out)
//   m_*                 shared Avalon master-side bus
//   owner               2'b00 none, 2'b01 I, 2'b10 D
//   proto_err           sticky: an owning master asserted read and write together
// -----------------------------------------------------------------------------
module mips_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  // master I
  input  logic [ADDR_W-1:0]     i_address,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [DATA_W-1:0]     i_writedata,
  input  logic [DATA_W/8-1:0]   i_byteenable,
  output logic                  i_waitrequest,
  output logic [DATA_W-1:0]     i_readdata,
  // master D
  input  logic [ADDR_W-1:0]     d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_W-1:0]     d_writedata,
  input  logic [DATA_W/8-1:0]   d_byteenable,
  output logic                  d_waitrequest,
  output logic [DATA_W-1:0]     d_readdata,
  // shared bus
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  // status
  output logic [1:0]            owner,
  output logic                  proto_err
);

  localparam int BE_W = DATA_W / 8;

  // The state encoding is also the owner encoding, so owner comes straight
  // from the state register.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_I = 2'b01,
    ST_OWN_D = 2'b10
  } state_t;

  state_t      state_r;
  logic        last_grant_r;   // 1'b0 = I was granted last, 1'b1 = D
  logic        proto_err_r;

  logic        req_i_s;
  logic        req_d_s;
  logic        pick_d_s;
  logic        proto_viol_s;

  // Arbitration on entry from IDLE. A lone requester wins. On a tie, fixed
  // priority favours D, and round-robin favours the master that was not
  // granted last.
  function automatic logic arb_pick_d(input logic req_i,
                                      input logic req_d,
                                      input logic last_d,
                                      input logic fixed_d);
    logic pick;
    if (req_i && req_d) begin
      if (fixed_d) begin
        pick = 1'b1;
      end else begin
        pick = ~last_d;
      end
    end else begin
      pick = req_d;
    end
    return pick;
  endfunction

  // Request decode and arbitration choice
  always_comb begin
    req_i_s  = i_read | i_write;
    req_d_s  = d_read | d_write;
    pick_d_s = arb_pick_d(req_i_s, req_d_s, last_grant_r, (FIXED_PRIO != 0));
  end

  // A read+write pair from the current owner is a protocol violation
  always_comb begin
    case (state_r)
      ST_OWN_I: proto_viol_s = i_read & i_write;
      ST_OWN_D: proto_viol_s = d_read & d_write;
      default:  proto_viol_s = 1'b0;
    endcase
  end

  // Bus mux. The m_* outputs depend only on state_r and the owner's request
  // inputs, never on m_waitrequest. A read+write pair goes out as a write.
  // When the owner drops its request, its strobes are already low, so
  // nothing is issued in that cycle.
  always_comb begin
    m_address     = {ADDR_W{1'b0}};
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = {DATA_W{1'b0}};
    m_byteenable  = {BE_W{1'b0}};
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (state_r)
      ST_OWN_I: begin
        m_address     = i_address;
        m_read        = i_read & ~i_write;
        m_write       = i_write;
        m_writedata   = i_writedata;
        m_byteenable  = i_byteenable;
        i_waitrequest = m_waitrequest;
      end
      ST_OWN_D: begin
        m_address     = d_address;
        m_read        = d_read & ~d_write;
        m_write       = d_write;
        m_writedata   = d_writedata;
        m_byteenable  = d_byteenable;
        d_waitrequest = m_waitrequest;
      end
      default: begin
        m_address     = {ADDR_W{1'b0}};
        m_read        = 1'b0;
        m_write       = 1'b0;
      end
    endcase
  end

  // Read data goes to both masters. Only the owner's waitrequest qualifies it.
  always_comb begin
    i_readdata = m_readdata;
    d_readdata = m_readdata;
    owner      = state_r;
    proto_err  = proto_err_r;
  end

  // Grant state machine. When the owner completes, ownership passes straight
  // to the other master if it is requesting. Otherwise the arbiter returns to
  // IDLE, so the same master cannot keep the bus without re-arbitrating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_i_s || req_d_s) begin
            state_r <= pick_d_s ? ST_OWN_D : ST_OWN_I;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_OWN_I: begin
          if (!req_i_s) begin
            state_r <= ST_IDLE;
          end else if (!m_waitrequest) begin
            last_grant_r <= 1'b0;
            state_r      <= req_d_s ? ST_OWN_D : ST_IDLE;
          end else begin
            state_r <= ST_OWN_I;
          end
        end
        ST_OWN_D: begin
          if (!req_d_s) begin
            state_r <= ST_IDLE;
          end else if (!m_waitrequest) begin
            last_grant_r <= 1'b1;
            state_r      <= req_i_s ? ST_OWN_I : ST_IDLE;
          end else begin
            state_r <= ST_OWN_D;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky protocol-error flag. Only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err_r <= 1'b0;
    end else if (proto_viol_s) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

endmodule
